// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types used by the fetch path.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead synchronous FIFO of {pc, instr} entries with occupancy count and flush.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = i_push & ~i_flush & (count_q != FULL_CNT);
  assign pop_ok  = i_pop & ~i_flush & (count_q != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (i_flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q] <= i_wdata;
  end

  // Head reads as zero when empty so decode never sees stale storage.
  assign o_valid = (count_q != '0);
  assign o_rdata = o_valid ? mem_q[rptr_q] : '0;
  assign o_count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited word reads and buffers responses
// for decode; redirects flush the buffer and drain stale in-flight responses.
module instr_fetch #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned      DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  import riscv_pkg::*;

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_sum;
  logic            credit_ok;
  logic            req, grant, rsp_ok, push, pop;
  logic [CW-1:0]   in_flight;
  logic [XLEN-1:0] target_pc;
  logic            fifo_valid;
  logic [2*XLEN-1:0] fifo_rdata;
  logic            unused_redirect_lsbs;

  assign target_pc            = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // Credit counts FIFO slots already promised to in-flight requests.
  assign credit_sum = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < {1'b0, DEPTH_C};

  assign req    = i_rst_n & (state_q == FETCH) & credit_ok & ~i_redirect;
  assign grant  = req & i_imem_gnt;
  assign rsp_ok = i_imem_rvalid & (outstanding_q != '0);
  assign push   = i_imem_rvalid & (state_q == FETCH) & ~i_redirect;
  assign pop    = fifo_valid & i_instr_ready & ~i_redirect;

  assign in_flight = outstanding_q + CW'(grant) - CW'(rsp_ok);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = in_flight;

    unique case (state_q)
      FETCH: begin
        if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);
      end
      DRAIN: begin
        if (rsp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        if (drop_cnt_d == '0) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect overrides everything; requests still in flight become stale.
    if (i_redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_cnt_d = in_flight;
      state_d    = (in_flight != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= START_PC;
      resp_pc_q     <= START_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (push),
    .i_wdata ({resp_pc_q, i_imem_rdata}),
    .i_pop   (pop),
    .o_valid (fifo_valid),
    .o_rdata (fifo_rdata),
    .o_count (fifo_count)
  );

  assign o_imem_req    = req;
  assign o_imem_addr   = fetch_pc_q;
  assign o_instr_valid = fifo_valid;
  assign o_instr_pc    = fifo_rdata[2*XLEN-1:XLEN];
  assign o_instr       = fifo_rdata[XLEN-1:0];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the RISC-V core: the producer side of the instruction stream that the control decoder consumes. It owns the PC, issues word reads to instruction memory over a request/grant/response-valid interface, and buffers returned words with their PCs in a small FIFO. It presents `{pc, instr}` to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

## Interface
- `XLEN`, 32: address and data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: FIFO entries; also the maximum number of outstanding memory requests (power of two, ≥2).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `o_imem_req`  out  1  read request valid.
- `o_imem_addr`  out  XLEN  word-aligned read address; bits [1:0] are always 0.
- `i_imem_gnt`  in  1  request accepted this cycle when `o_imem_req & i_imem_gnt`.
- `i_imem_rvalid`  in  1  response valid; responses return in request order, latency ≥1 cycle.
- `i_imem_rdata`  in  XLEN  response instruction word.
- `o_instr_valid`  out  1  FIFO head valid.
- `o_instr`  out  XLEN  instruction at the FIFO head.
- `o_instr_pc`  out  XLEN  PC of `o_instr`.
- `i_instr_ready`  in  1  decode accepts the head this cycle.
- `i_redirect`  in  1  taken branch/jump; one-cycle pulse.
- `i_redirect_pc`  in  XLEN  redirect target; bits [1:0] are ignored (forced to 0).

## Operation
- Registers: `fetch_pc`, `resp_pc`, `outstanding` (0..DEPTH), `drop_cnt` (0..DEPTH), `state`, and the FIFO.
- Credit: `credit_ok = (outstanding + fifo_count) < DEPTH`. This guarantees that every accepted response has a FIFO slot.
- States:
  - FETCH: `o_imem_req = credit_ok & ~i_redirect`. `o_imem_addr = fetch_pc`. On grant, `fetch_pc += 4` (modulo 2^XLEN wrap) and `outstanding` increments.
  - DRAIN: entered on a redirect when stale requests are in flight. `o_imem_req = 0`. Each `i_imem_rvalid` decrements `drop_cnt` and `outstanding`, and the data is discarded. Return to FETCH in the cycle after `drop_cnt` reaches 0.
- Response in FETCH: push `{resp_pc, i_imem_rdata}` into the FIFO, then `resp_pc += 4` and decrement `outstanding`.
- Pop on `o_instr_valid & i_instr_ready`.
- Redirect (any state):
  - The FIFO is flushed.
  - `fetch_pc` and `resp_pc` are set to `{i_redirect_pc[XLEN-1:2], 2'b00}`.
  - `drop_cnt` is set to the number of in-flight requests after this cycle's events: `outstanding` plus this cycle's grant, minus this cycle's rvalid. A response arriving in the redirect cycle is discarded.
  - Next state is DRAIN if that count is >0, otherwise FETCH.
- Simultaneous events:
  - A pop in the redirect cycle has no further effect; the flush dominates.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - A redirect during DRAIN accumulates onto the existing drop count: no new requests are issued in DRAIN, so the count stays equal to `outstanding`.
- `i_imem_rvalid` with `outstanding == 0` is a protocol violation. The bench asserts it never occurs; RTL behaviour is unspecified.

## Timing
- Reset values: `o_imem_req = 0` while `i_rst_n` is low; `o_instr_valid = 0`, `o_instr = 0`, `o_instr_pc = 0`.
- After reset: `fetch_pc = resp_pc = RESET_PC`, all counters 0, state FETCH.
- First request: `o_imem_req = 1` with `o_imem_addr = RESET_PC` in the first cycle after reset release.
- `o_imem_req`, `o_imem_addr` and `o_instr*` are combinational from registered state, except that `o_imem_req` is also gated by `i_redirect`.
- Latency: a response in cycle N produces `o_instr_valid = 1` in cycle N+1. There is no bypass.
- Throughput: one instruction per cycle sustained at 1-cycle memory latency with `i_instr_ready` held high.
- The redirect target's first request is issued in cycle R+1 if there was no stale traffic. Otherwise it is issued one cycle after the last stale response.
- Asynchronous reset mid-transfer: all state clears immediately. In-flight responses arriving after reset release are the system's responsibility; memory is reset together with this block.

## Structure
- `riscv_pkg` holds:
  - `XLEN`
  - `RESET_PC`
  - `NOP_INSTR = 32'h0000_0013`
  - the fetch state enum `{FETCH, DRAIN}`
- Sub-module `instr_fifo`: a synchronous FIFO of `{pc, instr}` entries, parameterised by `DEPTH`, with show-ahead head, `count` output and a `flush` input.

## Test plan
- Reset then 1-cycle memory, ready held high → requests at 0x0, 0x4, 0x8…; `o_instr_pc` follows 0x0, 0x4… from cycle 2 with one valid per cycle.
- `i_instr_ready = 0` with DEPTH=4 → exactly 4 grants, then `o_imem_req = 0`. Raising ready restores one request per pop.
- 3-cycle memory latency, redirect to 0x103 while 3 requests are in flight → 3 responses are dropped and none reach decode. The next request address is 0x100. The first output has `o_instr_pc = 0x100`.
- Redirect in the same cycle as rvalid and pop, FIFO holding 2 entries → FIFO empty next cycle and the response is not pushed.
- Second redirect to 0x200 during DRAIN → only the 0x200 stream appears at decode.
- `fetch_pc = 0xFFFF_FFFC` → next request address wraps to 0x0000_0000.
